regfile_dbg_ctrl: RTL and testbench
===================================

# regfile_dbg_ctrl

Debug/access controller in front of the LC-3 register file. It shares the single register-file write port between the CPU datapath and a debug host. It also sequences a full register dump (R0..R7) through the external viewing port, using a valid/ready stream. The CPU always has write priority; the block asserts `cpu_hold` to ask the control unit to stall while debug work is pending.

## Interface
Parameters: none (8 registers x 16 bits, fixed by the ISA).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `cpu_ld`  in  1  CPU register write enable (control-unit ldReg)
- `cpu_dr`  in  3  CPU destination register
- `cpu_data`  in  16  CPU write data (BUS)
- `dbg_wr_req`  in  1  debug write request
- `dbg_wr_addr`  in  3  debug write register index
- `dbg_wr_data`  in  16  debug write data
- `dbg_wr_ack`  out  1  one-cycle pulse: debug write committed
- `dump_start`  in  1  request a dump of R0..R7
- `dump_valid`  out  1  `dump_data` and `dump_idx` are valid
- `dump_ready`  in  1  consumer accepts the current word
- `dump_idx`  out  3  register index of `dump_data`
- `dump_data`  out  16  captured register value
- `dump_done`  out  1  one-cycle pulse after R7 is accepted
- `rf_ext_q`  in  16  register-file external read data (combinational from `rf_ext_sel`)
- `rf_ext_sel`  out  3  register-file external read select
- `rf_ld`  out  1  register-file write enable
- `rf_dr`  out  3  register-file destination select
- `rf_bus`  out  16  register-file write data
- `cpu_hold`  out  1  stall request to the control unit
- `busy`  out  1  state is not IDLE

## Operation
- States: IDLE, WPEND, DUMP_SEL, DUMP_OUT.
- **Reset values:**
  - State is IDLE.
  - `dbg_wr_ack`, `dump_valid`, `dump_done`, `cpu_hold` and `busy` are 0.
  - `dump_idx`, `dump_data` and `rf_ext_sel` are 0.
  - Write holding registers are 0.
- **Write-port mux (combinational):**
  - If `cpu_ld`=1: `rf_ld`=1, `rf_dr`=`cpu_dr`, `rf_bus`=`cpu_data`.
  - Else if state is WPEND: `rf_ld`=1 and the port is driven from the holding registers.
  - Else `rf_ld`=0, with `rf_dr` and `rf_bus` equal to the holding registers.
- **IDLE:**
  - `dbg_wr_req`=1: latch addr/data into the holding registers and go to WPEND.
  - Else `dump_start`=1: clear the index to 0 and go to DUMP_SEL.
  - Write takes priority; a simultaneous `dump_start` is dropped, so the host re-asserts it.
- **WPEND:**
  - On the first cycle with `cpu_ld`=0, the debug write commits at that edge.
  - The state returns to IDLE and `dbg_wr_ack` pulses in the following cycle.
  - `dbg_wr_req` is ignored while in WPEND.
- **DUMP_SEL:**
  - `rf_ext_sel`=index.
  - At the edge, capture `rf_ext_q` into `dump_data` and the index into `dump_idx`, set `dump_valid`=1, and go to DUMP_OUT.
- **DUMP_OUT:**
  - Hold `dump_valid`, `dump_data` and `dump_idx` stable until `dump_valid`&&`dump_ready`.
  - On the handshake, `dump_valid` drops at that edge.
  - If index=7: pulse `dump_done` next cycle and go to IDLE.
  - Else increment the index and go to DUMP_SEL.
- `cpu_hold`=1 in WPEND, DUMP_SEL and DUMP_OUT (registered, so it follows the state).
- **CPU writes during a dump** pass through untouched, because the CPU has priority. A register already captured reflects its pre-write value; a register not yet captured reflects the new value.
- **Index wrap:** there is none; the dump always ends after index 7.

## Timing
- **Debug write, CPU idle:**
  - Req sampled at edge N, WPEND during cycle N+1.
  - `rf_ld`=1 in cycle N+1; the register updates at edge N+2.
  - `dbg_wr_ack`=1 during cycle N+2.
- **Debug write blocked:** each cycle with `cpu_ld`=1 in WPEND delays the commit by one cycle. There is no timeout.
- **Dump:**
  - `dump_start` sampled at edge N.
  - DUMP_SEL during N+1; `dump_valid`=1 with R0 during N+2.
  - With `dump_ready` tied to 1, one word every 2 cycles, so R7 is valid in N+16.
  - `dump_done`=1 during N+17; IDLE in N+17.
- **`dump_ready` without valid:** has no effect.
- **Reset mid-operation:**
  - All outputs return to reset values immediately.
  - A pending debug write is discarded and never acked.
  - A partial dump is abandoned with no `dump_done`.

## Test plan
- **Debug write, CPU idle:** reset, `dbg_wr_req` with addr=3, data=0xBEEF, `cpu_ld`=0 -> `rf_ld`=1 and `rf_dr`=3 one cycle later; `dbg_wr_ack` pulses one cycle after that; R3 reads 0xBEEF.
- **Collision:** `cpu_ld`=1 for 3 cycles (dr=5, data=0x1111) while `dbg_wr_req` addr=5, data=0x2222 -> CPU writes pass, `cpu_hold`=1; the debug write commits the first cycle `cpu_ld`=0; final R5=0x2222; exactly one ack.
- **Dump:** preload Rn=0x1000+n, `dump_start` with `dump_ready`=1 -> 8 beats with idx 0..7 and data 0x1000..0x1007, 2 cycles apart; `dump_done` is a single pulse 17 cycles after start.
- **Backpressure:** `dump_ready`=0 for 5 cycles on beat 2 -> `dump_valid`, `dump_idx`=2 and `dump_data`=0x1002 stay stable; the sequence resumes intact.
- **Simultaneous start:** `dbg_wr_req` and `dump_start` in the same IDLE cycle -> the write is serviced and no dump starts.
- **Reset mid-dump:** assert `rst` during beat 4 -> `dump_valid`, `cpu_hold` and `busy` are 0 asynchronously; no `dump_done`; a new dump after reset starts at idx 0.

Source files
------------

// File: rtl/regfile_dbg_ctrl.sv
// regfile_dbg_ctrl: shares the LC-3 register-file write port between CPU and debug host, and streams R0..R7 dumps.
module regfile_dbg_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ld,
  input  logic [2:0]  cpu_dr,
  input  logic [15:0] cpu_data,
  input  logic        dbg_wr_req,
  input  logic [2:0]  dbg_wr_addr,
  input  logic [15:0] dbg_wr_data,
  output logic        dbg_wr_ack,
  input  logic        dump_start,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [2:0]  dump_idx,
  output logic [15:0] dump_data,
  output logic        dump_done,
  input  logic [15:0] rf_ext_q,
  output logic [2:0]  rf_ext_sel,
  output logic        rf_ld,
  output logic [2:0]  rf_dr,
  output logic [15:0] rf_bus,
  output logic        cpu_hold,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, WPEND, DUMP_SEL, DUMP_OUT} state_t;
  state_t state, state_n;
  logic [2:0] hold_addr, idx;
  logic [15:0] hold_data;
  logic hs, last;
  assign hs = state == DUMP_OUT && dump_ready;
  assign last = idx == 3'd7;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = dbg_wr_req ? WPEND : dump_start ? DUMP_SEL : IDLE;
      WPEND:    state_n = cpu_ld ? WPEND : IDLE;
      DUMP_SEL: state_n = DUMP_OUT;
      DUMP_OUT: state_n = !dump_ready ? DUMP_OUT : last ? IDLE : DUMP_SEL;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      hold_addr  <= '0;
      hold_data  <= '0;
      idx        <= '0;
      dump_idx   <= '0;
      dump_data  <= '0;
      dbg_wr_ack <= 1'b0;
      dump_done  <= 1'b0;
    end else begin
      state      <= state_n;
      dbg_wr_ack <= state == WPEND && !cpu_ld;
      dump_done  <= hs && last;
      if (state == IDLE && dbg_wr_req) begin
        hold_addr <= dbg_wr_addr;
        hold_data <= dbg_wr_data;
      end
      if (state == IDLE && !dbg_wr_req && dump_start) idx <= '0;
      if (hs && !last) idx <= idx + 3'd1;
      if (state == DUMP_SEL) begin
        dump_data <= rf_ext_q;
        dump_idx  <= idx;
      end
    end
  // CPU always owns the port when it writes; a pending debug write waits for a free cycle
  assign rf_ld      = cpu_ld || state == WPEND;
  assign rf_dr      = cpu_ld ? cpu_dr : hold_addr;
  assign rf_bus     = cpu_ld ? cpu_data : hold_data;
  assign rf_ext_sel = idx;
  assign dump_valid = state == DUMP_OUT;
  assign busy       = state != IDLE;
  assign cpu_hold   = state != IDLE;
endmodule

// File: tb/tb_regfile_dbg_ctrl.sv
// tb_regfile_dbg_ctrl: directed + randomized checks of regfile_dbg_ctrl against a register-array reference model.
module tb_regfile_dbg_ctrl;
  logic clk = 0, rst = 1;
  logic cpu_ld = 0, dbg_wr_req = 0, dump_start = 0, dump_ready = 0;
  logic [2:0] cpu_dr = 0, dbg_wr_addr = 0;
  logic [15:0] cpu_data = 0, dbg_wr_data = 0;
  logic dbg_wr_ack, dump_valid, dump_done, rf_ld, cpu_hold, busy;
  logic [2:0] dump_idx, rf_ext_sel, rf_dr;
  logic [15:0] dump_data, rf_ext_q, rf_bus;
  logic [15:0] rf [8];
  logic [15:0] exp_rf [8];
  int tests = 0, fails = 0;

  regfile_dbg_ctrl dut (
    .clk(clk), .rst(rst), .cpu_ld(cpu_ld), .cpu_dr(cpu_dr), .cpu_data(cpu_data),
    .dbg_wr_req(dbg_wr_req), .dbg_wr_addr(dbg_wr_addr), .dbg_wr_data(dbg_wr_data),
    .dbg_wr_ack(dbg_wr_ack), .dump_start(dump_start), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
    .dump_done(dump_done), .rf_ext_q(rf_ext_q), .rf_ext_sel(rf_ext_sel),
    .rf_ld(rf_ld), .rf_dr(rf_dr), .rf_bus(rf_bus), .cpu_hold(cpu_hold), .busy(busy)
  );

  always #5 clk = ~clk;
  always_ff @(posedge clk) if (rf_ld) rf[rf_dr] <= rf_bus;
  assign rf_ext_q = rf[rf_ext_sel];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // advance one cycle, applying the CPU write (if any) to the reference model
  task automatic tick;
    if (cpu_ld) exp_rf[cpu_dr] = cpu_data;
    step;
  endtask

  task automatic chk_rf;
    for (int n = 0; n < 8; n++) chk($sformatf("rf_r%0d", n), rf[n], exp_rf[n]);
  endtask

  // mode 0: ready always 1; mode 1: stall 5 cycles on beat 2; mode 2: random ready
  task automatic dump_run(input int mode);
    logic [15:0] snap [8];
    int c, beat, stall;
    logic r, done_due, got_done, prev_stall;
    snap = exp_rf;
    c = 0; beat = 0; stall = 0; done_due = 0; got_done = 0; prev_stall = 0;
    dump_ready = mode == 0;
    dump_start = 1;
    step;
    dump_start = 0;
    while (!got_done && c < 200) begin
      c++;
      if (done_due) begin
        chk("dump_done", dump_done, 1);
        chk("busy_after_dump", busy, 0);
        if (mode == 0) chk("done_latency", c, 17);
        got_done = 1;
      end else begin
        chk("no_early_done", dump_done, 0);
        if (prev_stall) chk("valid_held", dump_valid, 1);
        if (mode == 0) chk("beat_spacing", dump_valid, (c % 2 == 0) && c >= 2 && c <= 16);
        if (dump_valid) begin
          chk("dump_idx", dump_idx, beat);
          chk("dump_data", dump_data, snap[beat]);
          chk("hold_busy", cpu_hold, 1);
        end
        r = mode == 0 ? 1'b1 : mode == 1 ? !(beat == 2 && dump_valid && stall < 5) : 1'($urandom_range(1));
        if (mode == 1 && beat == 2 && dump_valid && !r) stall++;
        dump_ready = r;
        prev_stall = dump_valid && !r;
        if (dump_valid && r) begin
          if (beat == 7) done_due = 1;
          beat++;
        end
        step;
      end
    end
    chk("dump_finished", got_done, 1);
    chk("beat_count", beat, 8);
    if (mode == 1) chk("stall_cycles", stall, 5);
    step;
    chk("done_single_pulse", dump_done, 0);
    dump_ready = 0;
  endtask

  initial begin
    logic [2:0] a;
    logic [15:0] d;
    int k, acks;
    logic found;
    // reset state
    step;
    step;
    chk("rst_busy", busy, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_valid", dump_valid, 0);
    chk("rst_done", dump_done, 0);
    chk("rst_ack", dbg_wr_ack, 0);
    chk("rst_idx", dump_idx, 0);
    chk("rst_data", dump_data, 0);
    chk("rst_sel", rf_ext_sel, 0);
    chk("rst_rf_ld", rf_ld, 0);
    chk("rst_rf_dr", rf_dr, 0);
    chk("rst_rf_bus", rf_bus, 0);
    rst = 0;
    step;
    chk("idle_busy", busy, 0);
    // debug write with the CPU idle
    dbg_wr_req = 1; dbg_wr_addr = 3; dbg_wr_data = 16'hBEEF;
    tick;
    dbg_wr_req = 0;
    #1;
    chk("dw_rf_ld", rf_ld, 1);
    chk("dw_rf_dr", rf_dr, 3);
    chk("dw_rf_bus", rf_bus, 16'hBEEF);
    chk("dw_hold", cpu_hold, 1);
    chk("dw_no_ack_yet", dbg_wr_ack, 0);
    exp_rf[3] = 16'hBEEF;
    tick;
    chk("dw_ack", dbg_wr_ack, 1);
    chk("dw_idle", busy, 0);
    chk("dw_r3", rf[3], exp_rf[3]);
    step;
    chk("dw_ack_pulse", dbg_wr_ack, 0);
    // collision: CPU writes R5 for 3 cycles while the debug write to R5 waits
    cpu_ld = 1; cpu_dr = 5; cpu_data = 16'h1111;
    dbg_wr_req = 1; dbg_wr_addr = 5; dbg_wr_data = 16'h2222;
    tick;
    dbg_wr_req = 0; dbg_wr_addr = 0; dbg_wr_data = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("col_cpu_bus", rf_bus, 16'h1111);
      chk("col_hold", cpu_hold, 1);
      chk("col_no_ack", dbg_wr_ack, 0);
      tick;
    end
    cpu_ld = 0;
    #1;
    chk("col_dbg_bus", rf_bus, 16'h2222);
    chk("col_dbg_dr", rf_dr, 5);
    exp_rf[5] = 16'h2222;
    tick;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      if (dbg_wr_ack) acks++;
      step;
    end
    chk("col_one_ack", acks, 1);
    chk("col_r5", rf[5], exp_rf[5]);
    // preload Rn = 0x1000+n through the CPU path
    for (int n = 0; n < 8; n++) begin
      cpu_ld = 1; cpu_dr = 3'(n); cpu_data = 16'(16'h1000 + n);
      tick;
    end
    cpu_ld = 0;
    chk_rf;
    // dumps: free-running, then backpressure on beat 2
    dump_run(0);
    dump_run(1);
    // randomized debug writes against random CPU blocking
    for (int it = 0; it < 20; it++) begin
      a = 3'($urandom_range(7)); d = 16'($urandom); k = $urandom_range(3);
      dbg_wr_req = 1; dbg_wr_addr = a; dbg_wr_data = d;
      cpu_ld = 1'($urandom_range(1)); cpu_dr = 3'($urandom_range(7)); cpu_data = 16'($urandom);
      tick;
      dbg_wr_req = 0; dbg_wr_addr = 3'($urandom_range(7)); dbg_wr_data = 16'($urandom);
      for (int j = 0; j < k; j++) begin
        cpu_ld = 1; cpu_dr = 3'($urandom_range(7)); cpu_data = 16'($urandom);
        #1;
        chk("rw_blocked_no_ack", dbg_wr_ack, 0);
        chk("rw_busy", busy, 1);
        tick;
      end
      cpu_ld = 0;
      #1;
      chk("rw_rf_ld", rf_ld, 1);
      chk("rw_rf_dr", rf_dr, a);
      chk("rw_rf_bus", rf_bus, d);
      exp_rf[a] = d;
      tick;
      chk("rw_ack", dbg_wr_ack, 1);
      chk_rf;
    end
    dump_run(2);
    // simultaneous write request and dump start: only the write happens
    d = 16'($urandom);
    dbg_wr_req = 1; dbg_wr_addr = 6; dbg_wr_data = d; dump_start = 1;
    tick;
    dbg_wr_req = 0; dump_start = 0;
    #1;
    chk("sim_rf_ld", rf_ld, 1);
    chk("sim_rf_dr", rf_dr, 6);
    exp_rf[6] = d;
    tick;
    chk("sim_ack", dbg_wr_ack, 1);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("sim_no_dump", dump_valid, 0);
      chk("sim_idle", busy, 0);
    end
    chk("sim_r6", rf[6], exp_rf[6]);
    // reset discards a pending debug write
    d = 16'($urandom);
    dbg_wr_req = 1; dbg_wr_addr = 0; dbg_wr_data = d;
    tick;
    dbg_wr_req = 0;
    cpu_ld = 1; cpu_dr = 1; cpu_data = 16'($urandom);
    #1;
    rst = 1;
    #1;
    chk("rw_rst_busy", busy, 0);
    chk("rw_rst_cpu_pass", rf_ld, 1);
    tick;
    cpu_ld = 0;
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rw_rst_no_ack", dbg_wr_ack, 0);
      chk("rw_rst_bus", rf_bus, 0);
      step;
    end
    chk("rw_rst_r0", rf[0], exp_rf[0]);
    chk("rw_rst_r1", rf[1], exp_rf[1]);
    // reset during beat 4 of a dump
    dump_ready = 1; dump_start = 1;
    step;
    dump_start = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step;
      if (dump_valid && dump_idx == 4) found = 1;
    end
    chk("reach_beat4", found, 1);
    rst = 1;
    #1;
    chk("md_rst_valid", dump_valid, 0);
    chk("md_rst_hold", cpu_hold, 0);
    chk("md_rst_busy", busy, 0);
    chk("md_rst_idx", dump_idx, 0);
    chk("md_rst_data", dump_data, 0);
    step;
    step;
    rst = 0;
    dump_ready = 0;
    for (int i = 0; i < 20; i++) begin
      chk("md_no_done", dump_done, 0);
      step;
    end
    dump_run(0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
